// File: rtl/weight_mem_arbiter.sv
// Weight memory arbiter: one register array shared by inference reads,
// learning writes and host weight loads, with one access per cycle.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   rd_req, rd_addr               inference read request (pulse)
//   rd_valid, rd_data             read completion pulse, registered data
//   wr_req, wr_addr, wr_data      learning write request (pulse)
//   wr_ack                        write committed pulse
//   cfg_we, cfg_addr, cfg_data    host load request (pulse), top priority
//   cfg_ack                       host load committed pulse
//   busy                          any request pending
//   err                           sticky overrun flag
module weight_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              wr_ack,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DW-1:0]     cfg_data,
    output logic              cfg_ack,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_CFG
    } state_t;

    state_t st;
    state_t st_n;

    logic              pend_rd;
    logic              pend_wr;
    logic              pend_cfg;
    logic              last_wr;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] wr_a;
    logic [ADDR_W-1:0] cfg_a;
    logic [DW-1:0]     wr_d;
    logic [DW-1:0]     cfg_d;
    logic [DW-1:0]     mem [DEPTH];

    logic g_rd;
    logic g_wr;
    logic g_cfg;
    logic contest;
    logic ovr;

    always_comb begin
        g_cfg   = pend_cfg;
        contest = !pend_cfg && pend_rd && pend_wr;
        g_rd    = !pend_cfg && pend_rd && (!pend_wr || last_wr);
        g_wr    = !pend_cfg && pend_wr && (!pend_rd || !last_wr);
        st_n    = S_IDLE;
        unique case (1'b1)
            g_cfg:   st_n = S_CFG;
            g_rd:    st_n = S_RD;
            g_wr:    st_n = S_WR;
            default: st_n = S_IDLE;
        endcase
        // A pulse arriving while that port still waits is an overrun.
        ovr = (rd_req  && pend_rd  && !g_rd)
            | (wr_req  && pend_wr  && !g_wr)
            | (cfg_we  && pend_cfg && !g_cfg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            pend_rd  <= 1'b0;
            pend_wr  <= 1'b0;
            pend_cfg <= 1'b0;
            last_wr  <= 1'b1;
            err      <= 1'b0;
            rd_data  <= '0;
            rd_a     <= '0;
            wr_a     <= '0;
            cfg_a    <= '0;
            wr_d     <= '0;
            cfg_d    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            st <= st_n;
            if (ovr) begin
                err <= 1'b1;
            end
            // Round-robin bit moves only when rd and wr actually compete.
            if (contest) begin
                last_wr <= g_wr;
            end

            if (rd_req && (!pend_rd || g_rd)) begin
                pend_rd <= 1'b1;
                rd_a    <= rd_addr;
            end else if (g_rd) begin
                pend_rd <= 1'b0;
            end

            if (wr_req && (!pend_wr || g_wr)) begin
                pend_wr <= 1'b1;
                wr_a    <= wr_addr;
                wr_d    <= wr_data;
            end else if (g_wr) begin
                pend_wr <= 1'b0;
            end

            if (cfg_we && (!pend_cfg || g_cfg)) begin
                pend_cfg <= 1'b1;
                cfg_a    <= cfg_addr;
                cfg_d    <= cfg_data;
            end else if (g_cfg) begin
                pend_cfg <= 1'b0;
            end

            if (g_rd) begin
                rd_data <= mem[rd_a];
            end
            if (g_cfg) begin
                mem[cfg_a] <= cfg_d;
            end else if (g_wr) begin
                mem[wr_a] <= wr_d;
            end
        end
    end

    assign rd_valid = (st == S_RD);
    assign wr_ack   = (st == S_WR);
    assign cfg_ack  = (st == S_CFG);
    assign busy     = pend_rd | pend_wr | pend_cfg;

endmodule
